// File: rtl/reg_file_pkg.sv
// Shared constants and state encoding for the RV32I register file.
package reg_file_pkg;

   localparam int DEF_REG_NUM = 32;
   localparam int DEF_ADDR_W  = 5;
   localparam int DEF_DATA_W  = 32;

   localparam logic [DEF_DATA_W-1:0] ZERO          = '0;
   localparam logic [DEF_ADDR_W-1:0] ZERO_REG      = '0;
   localparam logic                  READ_ENABLE   = 1'b1;
   localparam logic                  READ_DISABLE  = 1'b0;
   localparam logic                  WRITE_ENABLE  = 1'b1;
   localparam logic                  WRITE_DISABLE = 1'b0;

   typedef enum logic {
      REGF_CLEAR = 1'b0,
      REGF_READY = 1'b1
   } regf_state_t;

endpackage

// File: rtl/reg_file_if.sv
// Bus between ID-stage decoders / write-back (master) and the register file (slave).
// Reads are combinational request/response; writes are fire-and-forget, taken on the edge.
interface reg_file_if;
   import reg_file_pkg::*;

   logic [DEF_ADDR_W-1:0] reg1_raddr_in;
   logic                  reg1_renable_in;
   logic [DEF_ADDR_W-1:0] reg2_raddr_in;
   logic                  reg2_renable_in;
   logic                  reg_wenable_in;
   logic [DEF_ADDR_W-1:0] reg_waddr_in;
   logic [DEF_DATA_W-1:0] reg_wdata_in;
   logic [DEF_DATA_W-1:0] reg1_rdata_out;
   logic [DEF_DATA_W-1:0] reg2_rdata_out;
   logic                  init_done_out;
   regf_state_t           dbg_state;

   modport master (
      output reg1_raddr_in, reg1_renable_in, reg2_raddr_in, reg2_renable_in,
             reg_wenable_in, reg_waddr_in, reg_wdata_in,
      input  reg1_rdata_out, reg2_rdata_out, init_done_out, dbg_state
   );

   modport slave (
      input  reg1_raddr_in, reg1_renable_in, reg2_raddr_in, reg2_renable_in,
             reg_wenable_in, reg_waddr_in, reg_wdata_in,
      output reg1_rdata_out, reg2_rdata_out, init_done_out, dbg_state
   );

endinterface

// File: rtl/reg_file_rport.sv
// One zero-latency read port: zero / write-through / stored-value select.
// Write-through forwarding is built only when REG_FILE_BYPASS_EN is defined.
module reg_file_rport
   import reg_file_pkg::*;
(
   input  logic                  renable,
   input  logic [DEF_ADDR_W-1:0] raddr,
   input  logic                  ready,
   input  logic                  wenable,
   input  logic [DEF_ADDR_W-1:0] waddr,
   input  logic [DEF_DATA_W-1:0] wdata,
   input  logic [DEF_DATA_W-1:0] stored,
   output logic [DEF_DATA_W-1:0] rdata
);

`ifdef REG_FILE_BYPASS_EN
   logic hit;
   assign hit = (wenable == WRITE_ENABLE) && (waddr == raddr);
`else
   logic unused_bypass;
   assign unused_bypass = ^{wenable, waddr, wdata};
`endif

   always_comb begin
      rdata = ZERO;
      // raddr != 0 also covers the bypass check against waddr != 0
      if (renable == READ_ENABLE && raddr != ZERO_REG && ready) begin
`ifdef REG_FILE_BYPASS_EN
         if (hit) rdata = wdata;
         else     rdata = stored;
`else
         rdata = stored;
`endif
      end
   end

endmodule

// File: rtl/reg_file.sv
// RV32I register file: 32x32 GPRs, two read ports, one write port, post-reset clear.
// Optional write-through forwarding on the read ports: REG_FILE_BYPASS_EN.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int REG_NUM = DEF_REG_NUM,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic       clk,
   input  logic       rst,
   reg_file_if.slave  bus
);

   regf_state_t       state;
   regf_state_t       next_state;
   logic [ADDR_W-1:0] clr_cnt;
   logic [DATA_W-1:0] regs [REG_NUM];
   logic              ready;

   always_ff @(posedge clk) begin
      if (rst) state <= REGF_CLEAR;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (state == REGF_CLEAR && clr_cnt == ADDR_W'(REG_NUM - 1))
         next_state = REGF_READY;
   end

   always_comb begin
      ready             = (state == REGF_READY);
      bus.init_done_out = ready;
      bus.dbg_state     = state;
   end

   always_ff @(posedge clk) begin
      if (rst)                      clr_cnt <= '0;
      else if (state == REGF_CLEAR) clr_cnt <= clr_cnt + 1'b1;
   end

   // Storage is not reset directly; the CLEAR walk zeroes it one entry per edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == REGF_CLEAR)
            regs[clr_cnt] <= ZERO;
         else if (bus.reg_wenable_in == WRITE_ENABLE && bus.reg_waddr_in != ZERO_REG)
            regs[bus.reg_waddr_in] <= bus.reg_wdata_in;
      end
   end

   reg_file_rport u_rport1 (
      .renable (bus.reg1_renable_in),
      .raddr   (bus.reg1_raddr_in),
      .ready   (ready),
      .wenable (bus.reg_wenable_in),
      .waddr   (bus.reg_waddr_in),
      .wdata   (bus.reg_wdata_in),
      .stored  (regs[bus.reg1_raddr_in]),
      .rdata   (bus.reg1_rdata_out)
   );

   reg_file_rport u_rport2 (
      .renable (bus.reg2_renable_in),
      .raddr   (bus.reg2_raddr_in),
      .ready   (ready),
      .wenable (bus.reg_wenable_in),
      .waddr   (bus.reg_waddr_in),
      .wdata   (bus.reg_wdata_in),
      .stored  (regs[bus.reg2_raddr_in]),
      .rdata   (bus.reg2_rdata_out)
   );

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: edge-counting behavioural model checked every cycle plus directed literals.
module tb_reg_file;
   import reg_file_pkg::*;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reg_file_if bus ();

   reg_file dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_pass  = 0;
   int n_total = 0;

   // model: edges since the last reset edge, and architectural contents
   logic [31:0] m_mem [32];
   int          m_edges = 0;
   bit          chk_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   function automatic logic [31:0] m_read(input logic ren, input logic [4:0] ra);
      if (!ren || ra == 5'd0 || m_edges < 32) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
      if (bus.reg_wenable_in && bus.reg_waddr_in != 5'd0 && bus.reg_waddr_in == ra)
         return bus.reg_wdata_in;
`endif
      return m_mem[ra];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_edges = 0;
         for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
         chk_en = 1'b1;
      end else begin
         if (m_edges >= 32 && bus.reg_wenable_in && bus.reg_waddr_in != 5'd0)
            m_mem[bus.reg_waddr_in] = bus.reg_wdata_in;
         if (m_edges < 32) m_edges++;
      end
   end

   // compare process, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_rd1", bus.reg1_rdata_out, m_read(bus.reg1_renable_in, bus.reg1_raddr_in));
         check("cyc_rd2", bus.reg2_rdata_out, m_read(bus.reg2_renable_in, bus.reg2_raddr_in));
         check("cyc_init_done", {31'h0, bus.init_done_out}, (m_edges >= 32) ? 32'h1 : 32'h0);
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_w(input logic en, input logic [4:0] a, input logic [31:0] d);
      bus.reg_wenable_in = en;
      bus.reg_waddr_in   = a;
      bus.reg_wdata_in   = d;
   endtask

   task automatic set_r(input logic en1, input logic [4:0] a1, input logic en2, input logic [4:0] a2);
      bus.reg1_renable_in = en1;
      bus.reg1_raddr_in   = a1;
      bus.reg2_renable_in = en2;
      bus.reg2_raddr_in   = a2;
   endtask

   logic [4:0]  wa_tab [4] = '{5'd1, 5'd31, 5'd16, 5'd5};
   logic [31:0] wd_tab [4] = '{32'h0000_0001, 32'h8000_0000, 32'h1234_ABCD, 32'hFFFF_FFFF};

   initial begin
      rst = 1'b1;
      set_w(1'b0, 5'd0, 32'h0);
      set_r(1'b0, 5'd0, 1'b0, 5'd0);
      step();
      check("rst_init_done", {31'h0, bus.init_done_out}, 32'h0);
      check("rst_rd1", bus.reg1_rdata_out, 32'h0);
      rst = 1'b0;

      // 1: clear sequence length
      for (int i = 1; i <= 32; i++) begin
         step();
         if (i == 31) check("init_lo_e31", {31'h0, bus.init_done_out}, 32'h0);
         if (i == 32) check("init_hi_e32", {31'h0, bus.init_done_out}, 32'h1);
      end
      for (int a = 1; a < 32; a++) begin
         set_r(1'b1, 5'(a), 1'b1, 5'(32 - a));
         #1;
         check("cleared_rd1", bus.reg1_rdata_out, 32'h0);
         check("cleared_rd2", bus.reg2_rdata_out, 32'h0);
         step();
      end

      // 2: write then read next cycle
      set_r(1'b0, 5'd0, 1'b0, 5'd0);
      set_w(1'b1, 5'd5, 32'hDEAD_BEEF);
      step();
      set_w(1'b0, 5'd0, 32'h0);
      set_r(1'b1, 5'd5, 1'b0, 5'd0);
      #1 check("x5_read", bus.reg1_rdata_out, 32'hDEAD_BEEF);

      // 3: x0 is hardwired
      step();
      set_w(1'b1, 5'd0, 32'h1234_5678);
      step();
      set_w(1'b0, 5'd0, 32'h0);
      set_r(1'b1, 5'd0, 1'b1, 5'd0);
      #1 check("x0_rd1", bus.reg1_rdata_out, 32'h0);
      check("x0_rd2", bus.reg2_rdata_out, 32'h0);

      // 4: same-cycle write/read
      step();
      set_w(1'b1, 5'd7, 32'hA5A5_A5A5);
      set_r(1'b0, 5'd0, 1'b1, 5'd7);
`ifdef REG_FILE_BYPASS_EN
      #1 check("x7_same_cycle", bus.reg2_rdata_out, 32'hA5A5_A5A5);
`else
      #1 check("x7_same_cycle", bus.reg2_rdata_out, 32'h0);
`endif
      step();
      set_w(1'b0, 5'd0, 32'h0);
      #1 check("x7_next_cycle", bus.reg2_rdata_out, 32'hA5A5_A5A5);

      // 5: disabled read port
      step();
      set_w(1'b1, 5'd9, 32'h0000_00FF);
      step();
      set_w(1'b0, 5'd0, 32'h0);
      set_r(1'b0, 5'd9, 1'b1, 5'd9);
      #1 check("x9_ren0", bus.reg1_rdata_out, 32'h0);
      check("x9_rd2", bus.reg2_rdata_out, 32'h0000_00FF);

      // directed table: boundary addresses, overwrite of x5, both ports same address
      for (int i = 0; i < 4; i++) begin
         step();
         set_w(1'b1, wa_tab[i], wd_tab[i]);
      end
      step();
      set_w(1'b0, 5'd0, 32'h0);
      set_r(1'b1, 5'd31, 1'b1, 5'd31);
      #1 check("x31_rd1", bus.reg1_rdata_out, 32'h8000_0000);
      check("x31_rd2", bus.reg2_rdata_out, 32'h8000_0000);
      step();
      set_r(1'b1, 5'd1, 1'b1, 5'd5);
      #1 check("x1_rd1", bus.reg1_rdata_out, 32'h0000_0001);
      check("x5_over_rd2", bus.reg2_rdata_out, 32'hFFFF_FFFF);
      step();
      set_r(1'b1, 5'd16, 1'b1, 5'd7);
      #1 check("x16_rd1", bus.reg1_rdata_out, 32'h1234_ABCD);
      check("x7_keep_rd2", bus.reg2_rdata_out, 32'hA5A5_A5A5);

      // 6: reset, then reset again mid-clear, with writes during CLEAR
      step();
      rst = 1'b1;
      set_w(1'b1, 5'd5, 32'hCAFE_F00D);
      step();
      rst = 1'b0;
      set_w(1'b0, 5'd0, 32'h0);
      check("rst2_init_done", {31'h0, bus.init_done_out}, 32'h0);
      for (int i = 1; i <= 9; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_w(1'b1, 5'd3, 32'h1111_1111);
      for (int i = 1; i <= 32; i++) begin
         step();
         if (i == 5) set_w(1'b0, 5'd0, 32'h0);
         if (i == 31) check("restart_lo_e31", {31'h0, bus.init_done_out}, 32'h0);
         if (i == 32) check("restart_hi_e32", {31'h0, bus.init_done_out}, 32'h1);
      end
      set_r(1'b1, 5'd3, 1'b1, 5'd5);
      #1 check("x3_after_restart", bus.reg1_rdata_out, 32'h0);
      check("x5_after_restart", bus.reg2_rdata_out, 32'h0);
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
